// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, grant-state encoding and zero-register constant for the write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef enum logic {
    GRANT0 = 1'b0,
    GRANT1 = 1'b1
  } grant_e;

endpackage

// File: rtl/rf_wb_rr_pick.sv
// Grant selection between the ALU (0) and load (1) write-back requesters.
// RF_WB_RR_EN selects round-robin on contention; otherwise the load always wins.
module rf_wb_rr_pick
  import rf_wb_arbiter_pkg::*;
(
  input  logic   valid0,
  input  logic   valid1,
  input  grant_e last_grant,
  output logic   grant0,
  output logic   grant1
);

`ifdef RF_WB_RR_EN
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      // Favour whoever did not win last time.
      if (last_grant == GRANT0) grant1 = 1'b1;
      else                      grant0 = 1'b1;
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant0 = valid0 & ~valid1;
    grant1 = valid1;
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: two requesters, one registered write port, read-hazard flag.
// Optional macro RF_WB_RR_EN enables round-robin arbitration on contention.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic [AW-1:0] rA,
  input  logic [AW-1:0] rB,
  output logic          wE,
  output logic [AW-1:0] rW,
  output logic [DW-1:0] busW,
  output logic          hazard
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  grant_e        last_grant_q, last_grant_d;
  logic          grant0, grant1;
  logic          accept0, accept1;
  logic          we_q;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] busw_q;

  rf_wb_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Output process: nothing is granted while reset is held.
  always_comb begin
    req0_ready = grant0 & ~rst;
    req1_ready = grant1 & ~rst;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept0)      last_grant_d = GRANT0;
    else if (accept1) last_grant_d = GRANT1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT1;
      we_q         <= 1'b0;
      rw_q         <= '0;
      busw_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= (accept0 && req0_addr != ZeroAddr) || (accept1 && req1_addr != ZeroAddr);
      if (accept0) begin
        rw_q   <= req0_addr;
        busw_q <= req0_data;
      end else if (accept1) begin
        rw_q   <= req1_addr;
        busw_q <= req1_data;
      end
    end
  end

  // A write already staged is squashed as soon as reset is seen.
  assign wE   = we_q & ~rst;
  assign rW   = rw_q;
  assign busW = busw_q;

  assign hazard = wE && (((rw_q == rA) && (rA != ZeroAddr)) ||
                         ((rw_q == rB) && (rB != ZeroAddr)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed cases plus randomized traffic vs. a rule model.
module tb_rf_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] rA, rB;
  logic          wE;
  logic [AW-1:0] rW;
  logic [DW-1:0] busW;
  logic          hazard;

  int tests = 0;
  int fails = 0;

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rA         (rA),
    .rB         (rB),
    .wE         (wE),
    .rW         (rW),
    .busW       (busW),
    .hazard     (hazard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Contention rule taken straight from the requirements; -1 means nobody is valid.
  function automatic int winner(input logic v0, input logic v1, input int last);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef RF_WB_RR_EN
    return (last == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // Reference model: state of the write port as seen during the current cycle.
  int            m_last;
  logic          m_we;
  logic [AW-1:0] m_rw;
  logic [DW-1:0] m_busw;
  logic          m_known;
  logic          m_init = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_wE", wE, 1'b0);
        chk("rst_hazard", hazard, 1'b0);
        m_last  = 1;
        m_we    = 1'b0;
        m_rw    = '0;
        m_busw  = '0;
        m_known = 1'b1;
        m_init  = 1'b1;
      end else if (m_init) begin
        int w;
        logic exp_haz;
        w = winner(req0_valid, req1_valid, m_last);
        exp_haz = m_we && ((m_rw == rA && rA != 0) || (m_rw == rB && rB != 0));
        chk("model_ready0", req0_ready, w == 0);
        chk("model_ready1", req1_ready, w == 1);
        chk("model_wE", wE, m_we);
        chk("model_hazard", hazard, exp_haz);
        if (m_known) begin
          chk("model_rW", rW, m_rw);
          chk("model_busW", busW, m_busw);
        end
        if (w >= 0) begin
          m_last  = w;
          m_rw    = (w == 0) ? req0_addr : req1_addr;
          m_busw  = (w == 0) ? req0_data : req1_data;
          m_we    = (m_rw != 0);
          m_known = m_we;
        end else begin
          m_we = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic r, input logic v0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    @(posedge clk);
    #1;
    rst = r;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rA = ra; rB = rb;
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra, rb);
  endtask

  initial begin
    logic hold0, hold1;
    int exp_first;
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rA = '0; rB = '0;

    // Reset with requests pending: nothing granted, outputs cleared.
    drive(1'b1, 1'b1, 5'd4, 32'h1, 1'b1, 5'd5, 32'h2, '0, '0);
    drive(1'b1, 1'b1, 5'd4, 32'h1, 1'b1, 5'd5, 32'h2, '0, '0);
    @(negedge clk);
    chk("reset_ready0", req0_ready, 1'b0);
    chk("reset_ready1", req1_ready, 1'b0);
    chk("reset_wE", wE, 1'b0);
    chk("reset_rW", rW, 5'd0);
    chk("reset_busW", busW, 32'd0);

    // Four cycles of contention straight out of reset.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, '0, '0);
      @(negedge clk);
`ifdef RF_WB_RR_EN
      chk("contend_ready0", req0_ready, (i % 2) == 0);
      chk("contend_ready1", req1_ready, (i % 2) == 1);
`else
      chk("contend_ready0", req0_ready, 1'b0);
      chk("contend_ready1", req1_ready, 1'b1);
`endif
    end
    idle('0, '0);

    // Lone requester 0.
    drive(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    chk("lone0_ready", req0_ready, 1'b1);
    idle('0, '0);
    @(negedge clk);
    chk("lone0_wE", wE, 1'b1);
    chk("lone0_rW", rW, 5'd3);
    chk("lone0_busW", busW, 32'hDEADBEEF);
    idle('0, '0);
    @(negedge clk);
    chk("idle_wE", wE, 1'b0);
    chk("idle_rW", rW, 5'd3);
    chk("idle_busW", busW, 32'hDEADBEEF);

    // Write to register zero is consumed but never enabled.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h5, '0, '0);
    @(negedge clk);
    chk("zero_ready1", req1_ready, 1'b1);
    idle('0, '0);
    @(negedge clk);
    chk("zero_wE", wE, 1'b0);

    // Hazard cases around a write to r7.
    drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, '0, '0);
    drive(1'b0, 1'b1, 5'd7, 32'h78, 1'b0, '0, '0, 5'd7, 5'd0);
    @(negedge clk);
    chk("haz_match", hazard, 1'b1);
    idle(5'd0, 5'd0);
    @(negedge clk);
    chk("haz_we_held", wE, 1'b1);
    chk("haz_zero_reads", hazard, 1'b0);
    idle(5'd7, 5'd0);
    @(negedge clk);
    chk("haz_no_we", hazard, 1'b0);

    // Reset right behind an accept cancels the staged write.
    drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0, '0, '0);
    drive(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, '0, '0);
    @(negedge clk);
    chk("rstcancel_wE_n1", wE, 1'b0);
    chk("rstcancel_ready0", req0_ready, 1'b0);
    chk("rstcancel_ready1", req1_ready, 1'b0);
    idle('0, '0);
    @(negedge clk);
    chk("rstcancel_wE_n2", wE, 1'b0);
    drive(1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hC1, '0, '0);
    @(negedge clk);
`ifdef RF_WB_RR_EN
    exp_first = 0;
`else
    exp_first = 1;
`endif
    chk("first_contend_ready0", req0_ready, exp_first == 0);
    chk("first_contend_ready1", req1_ready, exp_first == 1);

    // Randomized traffic; losers hold their request until served.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hold0 = req0_valid && !req0_ready;
      hold1 = req1_valid && !req1_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 39) == 0);
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = AW'($urandom_range(0, 9));
        req0_data  = $urandom;
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = AW'($urandom_range(0, 9));
        req1_data  = $urandom;
      end
      rA = AW'($urandom_range(0, 9));
      rB = AW'($urandom_range(0, 9));
    end

    idle('0, '0);
    @(negedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
